sdram_arb_rr: RTL and testbench

- N-port round-robin arbiter sharing one SDRAM controller core command port between several requesters (CPU, video fetch, DMA).
- Replaces fixed-priority sharing with fair rotation.
- Holds a grant from selection through core completion.
- Adds an accept-timeout watchdog so a never-accepted command cannot wedge the shared port.

---
 rtl/sdram_arb_rr_pkg.sv | 15 +
 rtl/sdram_arb_rr_if.sv | 42 ++++
 rtl/sdram_arb_rr_pick.sv | 28 ++
 rtl/sdram_arb_rr.sv | 158 +++++++++++++++
 tb/tb_sdram_arb_rr.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_rr_pkg.sv
// Shared types and bus widths for the round-robin SDRAM command-port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam int SDRAM_ADDR_W = 32;
  localparam int SDRAM_DATA_W = 32;
  localparam int SDRAM_LEN_W  = 8;
  localparam int SDRAM_BE_W   = 4;

endpackage

// File: rtl/sdram_arb_rr_if.sv
// Requester-side and core-side bus bundle of the SDRAM arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface sdram_arb_rr_if #(
  parameter int NUM_PORTS = 3
);
  import sdram_arb_pkg::*;

  logic [NUM_PORTS*SDRAM_BE_W-1:0]   req_wr_i;
  logic [NUM_PORTS-1:0]              req_rd_i;
  logic [NUM_PORTS*SDRAM_LEN_W-1:0]  req_len_i;
  logic [NUM_PORTS*SDRAM_ADDR_W-1:0] req_addr_i;
  logic [NUM_PORTS*SDRAM_DATA_W-1:0] req_write_data_i;
  logic [NUM_PORTS-1:0]              req_accept_o;
  logic [NUM_PORTS-1:0]              req_ack_o;
  logic [NUM_PORTS-1:0]              req_error_o;
  logic [SDRAM_DATA_W-1:0]           req_read_data_o;

  logic [SDRAM_BE_W-1:0]             core_wr_o;
  logic                              core_rd_o;
  logic [SDRAM_LEN_W-1:0]            core_len_o;
  logic [SDRAM_ADDR_W-1:0]           core_addr_o;
  logic [SDRAM_DATA_W-1:0]           core_write_data_o;
  logic                              core_accept_i;
  logic                              core_ack_i;
  logic                              core_error_i;
  logic [SDRAM_DATA_W-1:0]           core_read_data_i;

  modport slave (
    input  req_wr_i, req_rd_i, req_len_i, req_addr_i, req_write_data_i,
    input  core_accept_i, core_ack_i, core_error_i, core_read_data_i,
    output req_accept_o, req_ack_o, req_error_o, req_read_data_o,
    output core_wr_o, core_rd_o, core_len_o, core_addr_o, core_write_data_o
  );

  modport master (
    output req_wr_i, req_rd_i, req_len_i, req_addr_i, req_write_data_i,
    output core_accept_i, core_ack_i, core_error_i, core_read_data_i,
    input  req_accept_o, req_ack_o, req_error_o, req_read_data_o,
    input  core_wr_o, core_rd_o, core_len_o, core_addr_o, core_write_data_o
  );

endinterface

// File: rtl/sdram_arb_rr_pick.sv
// Rotating-priority selector: finds the first requester after ptr_i, wrapping
// modulo NUM_PORTS, so the most recent winner has the lowest priority.
module sdram_rr_pick #(
  parameter int NUM_PORTS = 3,
  localparam int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o
);

  // Scan from farthest to nearest so the nearest requester after ptr_i is kept last.
  always_comb begin
    int c;
    c       = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      c = (int'(ptr_i) + k) % NUM_PORTS;
      if (req_i[c]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/sdram_arb_rr.sv
// Round-robin arbiter sharing one SDRAM core command port among NUM_PORTS
// requesters. A grant is held from selection until core completion, and an
// accept watchdog aborts commands the core never takes.
module sdram_arb_rr
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 3,
  parameter int ACCEPT_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sdram_arb_rr_if.slave        bus,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic                 busy_o
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int TMO_W = (ACCEPT_TIMEOUT > 0) ? $clog2(ACCEPT_TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_CMD  = 2'(CMD);
  localparam logic [1:0] ST_WAIT = 2'(WAIT);

  logic [1:0]           state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [NUM_PORTS-1:0] gnt_q;
  logic [TMO_W-1:0]     tmo_cnt;

  logic [NUM_PORTS-1:0] req_vec;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  logic [SDRAM_BE_W-1:0]   sel_wr;
  logic                    sel_rd;
  logic [SDRAM_LEN_W-1:0]  sel_len;
  logic [SDRAM_ADDR_W-1:0] sel_addr;
  logic [SDRAM_DATA_W-1:0] sel_wdata;
  logic                    cur_req;
  logic                    tmo_expire;
  logic                    tmo_abort;

  // A port requests when it asks for a read or has any byte-enable set.
  always_comb begin
    req_vec = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_vec[p] = bus.req_rd_i[p] | (|bus.req_wr_i[p*SDRAM_BE_W +: SDRAM_BE_W]);
    end
  end

  sdram_rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req_i   (req_vec),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // ptr_q doubles as the owner index while a grant is held.
  assign sel_wr    = bus.req_wr_i[ptr_q*SDRAM_BE_W +: SDRAM_BE_W];
  assign sel_rd    = bus.req_rd_i[ptr_q];
  assign sel_len   = bus.req_len_i[ptr_q*SDRAM_LEN_W +: SDRAM_LEN_W];
  assign sel_addr  = bus.req_addr_i[ptr_q*SDRAM_ADDR_W +: SDRAM_ADDR_W];
  assign sel_wdata = bus.req_write_data_i[ptr_q*SDRAM_DATA_W +: SDRAM_DATA_W];
  assign cur_req   = req_vec[ptr_q];

  // Watchdog fires on the last allowed CMD cycle; an accept or a withdrawal
  // in that same cycle takes precedence and suppresses the error.
  assign tmo_expire = (ACCEPT_TIMEOUT != 0) && (tmo_cnt == TMO_W'(ACCEPT_TIMEOUT - 1));
  assign tmo_abort  = (state_q == ST_CMD) && !bus.core_accept_i && cur_req && tmo_expire;

  // Arbitration state, owner pointer, grant and watchdog counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(NUM_PORTS - 1);
      gnt_q   <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            ptr_q   <= pick_idx;
            gnt_q   <= NUM_PORTS'(1) << pick_idx;
            tmo_cnt <= '0;
            state_q <= ST_CMD;
          end
        end
        ST_CMD: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (bus.core_accept_i) begin
            if (bus.core_ack_i) begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
            end else begin
              state_q <= ST_WAIT;
            end
          end else if (!cur_req || tmo_abort) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
          end
        end
        ST_WAIT: begin
          if (bus.core_ack_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Route the owner's command to the core and core responses back to the owner only.
  always_comb begin
    bus.core_wr_o         = '0;
    bus.core_rd_o         = 1'b0;
    bus.core_len_o        = '0;
    bus.core_addr_o       = '0;
    bus.core_write_data_o = '0;
    bus.req_accept_o      = '0;
    bus.req_ack_o         = '0;
    bus.req_error_o       = '0;
    bus.req_read_data_o   = '0;
    case (state_q)
      ST_CMD: begin
        bus.core_wr_o         = tmo_abort ? '0 : sel_wr;
        bus.core_rd_o         = tmo_abort ? 1'b0 : sel_rd;
        bus.core_len_o        = sel_len;
        bus.core_addr_o       = sel_addr;
        bus.core_write_data_o = sel_wdata;
        bus.req_accept_o      = gnt_q & {NUM_PORTS{bus.core_accept_i}};
        if (bus.core_accept_i && bus.core_ack_i) begin
          bus.req_ack_o       = gnt_q;
          bus.req_error_o     = gnt_q & {NUM_PORTS{bus.core_error_i}};
          bus.req_read_data_o = bus.core_read_data_i;
        end else if (tmo_abort) begin
          bus.req_ack_o   = gnt_q;
          bus.req_error_o = gnt_q;
        end
      end
      ST_WAIT: begin
        bus.req_ack_o       = gnt_q & {NUM_PORTS{bus.core_ack_i}};
        bus.req_error_o     = gnt_q & {NUM_PORTS{bus.core_error_i}};
        bus.req_read_data_o = bus.core_read_data_i;
      end
      default: begin
      end
    endcase
  end

  assign grant_o = gnt_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_arb_rr.sv
// Directed bench for the round-robin SDRAM arbiter: vector table for single,
// merged accept/ack and rotation transactions, hand sequences for the
// watchdog, withdrawal and asynchronous reset cases.
module tb_sdram_arb_rr;

  typedef struct packed {
    logic [2:0]  rd;
    logic [11:0] wr;
    logic        acc;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
  } in_t;

  typedef struct packed {
    logic [2:0]  gnt;
    logic        busy;
    logic        crd;
    logic [3:0]  cwr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] wdata;
    logic [2:0]  acc;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [2:0] grant;
  logic       busy;
  int         checks;
  int         errors;
  vec_t       vecs[$];

  sdram_arb_rr_if #(.NUM_PORTS(3)) bus ();

  sdram_arb_rr #(
    .NUM_PORTS      (3),
    .ACCEPT_TIMEOUT (4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .grant_o (grant),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] port_addr(int p);
    case (p)
      0:       return 32'h0000_0040;
      1:       return 32'h0000_0100;
      default: return 32'h0000_0200;
    endcase
  endfunction

  function automatic logic [7:0] port_len(int p);
    case (p)
      0:       return 8'd4;
      1:       return 8'd0;
      default: return 8'd1;
    endcase
  endfunction

  function automatic logic [31:0] port_wdata(int p);
    case (p)
      0:       return 32'h1111_0000;
      1:       return 32'h2222_0000;
      default: return 32'h1234_5678;
    endcase
  endfunction

  function automatic in_t mk_in(logic [2:0] rd, logic [11:0] wr, logic acc, logic ack,
                                logic err, logic [31:0] rdata);
    in_t v;
    v.rd = rd; v.wr = wr; v.acc = acc; v.ack = ack; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  function automatic exp_t e_idle();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t e_cmd(int p, logic rd, logic [3:0] wr);
    exp_t e;
    e       = '0;
    e.gnt   = 3'b001 << p;
    e.busy  = 1'b1;
    e.crd   = rd;
    e.cwr   = wr;
    e.addr  = port_addr(p);
    e.len   = port_len(p);
    e.wdata = port_wdata(p);
    return e;
  endfunction

  function automatic exp_t e_wait(int p);
    exp_t e;
    e      = '0;
    e.gnt  = 3'b001 << p;
    e.busy = 1'b1;
    return e;
  endfunction

  task automatic check_eq(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply_stimulus(in_t v);
    @(negedge clk);
    bus.req_rd_i         = v.rd;
    bus.req_wr_i         = v.wr;
    bus.core_accept_i    = v.acc;
    bus.core_ack_i       = v.ack;
    bus.core_error_i     = v.err;
    bus.core_read_data_i = v.rdata;
    #1;
  endtask

  task automatic check_output(exp_t e, string tag);
    check_eq({tag, ".grant"},  32'(grant),                 32'(e.gnt));
    check_eq({tag, ".busy"},   32'(busy),                  32'(e.busy));
    check_eq({tag, ".c_rd"},   32'(bus.core_rd_o),         32'(e.crd));
    check_eq({tag, ".c_wr"},   32'(bus.core_wr_o),         32'(e.cwr));
    check_eq({tag, ".c_addr"}, bus.core_addr_o,            e.addr);
    check_eq({tag, ".c_len"},  32'(bus.core_len_o),        32'(e.len));
    check_eq({tag, ".c_wdat"}, bus.core_write_data_o,      e.wdata);
    check_eq({tag, ".accept"}, 32'(bus.req_accept_o),      32'(e.acc));
    check_eq({tag, ".ack"},    32'(bus.req_ack_o),         32'(e.ack));
    check_eq({tag, ".error"},  32'(bus.req_error_o),       32'(e.err));
    check_eq({tag, ".rdata"},  bus.req_read_data_o,        e.rdata);
  endtask

  task automatic step(in_t v, exp_t e, string tag);
    apply_stimulus(v);
    check_output(e, tag);
  endtask

  initial begin
    exp_t e;
    checks = 0;
    errors = 0;

    bus.req_addr_i       = {32'h0000_0200, 32'h0000_0100, 32'h0000_0040};
    bus.req_len_i        = {8'd1, 8'd0, 8'd4};
    bus.req_write_data_i = {32'h1234_5678, 32'h2222_0000, 32'h1111_0000};
    bus.req_rd_i         = '0;
    bus.req_wr_i         = '0;
    bus.core_accept_i    = 1'b0;
    bus.core_ack_i       = 1'b0;
    bus.core_error_i     = 1'b0;
    bus.core_read_data_i = '0;
    rst = 1'b1;
    #12;
    check_output(e_idle(), "reset");
    @(negedge clk);
    rst = 1'b0;

    // Single read on port 1: accept on the third CMD cycle, ack five cycles later.
    vecs.push_back({mk_in(3'b010, 12'h000, 0, 0, 0, 32'h0), e_idle()});
    vecs.push_back({mk_in(3'b010, 12'h000, 0, 0, 0, 32'h0), e_cmd(1, 1, 4'h0)});
    vecs.push_back({mk_in(3'b010, 12'h000, 0, 0, 0, 32'h0), e_cmd(1, 1, 4'h0)});
    e = e_cmd(1, 1, 4'h0); e.acc = 3'b010;
    vecs.push_back({mk_in(3'b010, 12'h000, 1, 0, 0, 32'h0), e});
    for (int k = 0; k < 4; k++)
      vecs.push_back({mk_in(3'b000, 12'h000, 0, 0, 0, 32'h0), e_wait(1)});
    e = e_wait(1); e.ack = 3'b010; e.rdata = 32'hDEAD_BEEF;
    vecs.push_back({mk_in(3'b000, 12'h000, 0, 1, 0, 32'hDEAD_BEEF), e});
    vecs.push_back({mk_in(3'b000, 12'h000, 1, 1, 1, 32'hAAAA_5555), e_idle()});

    // Port 2 write accepted and acknowledged in the same cycle.
    vecs.push_back({mk_in(3'b000, 12'hF00, 0, 0, 0, 32'h0), e_idle()});
    e = e_cmd(2, 0, 4'hF); e.acc = 3'b100; e.ack = 3'b100;
    vecs.push_back({mk_in(3'b000, 12'hF00, 1, 1, 0, 32'h0), e});
    vecs.push_back({mk_in(3'b000, 12'h000, 0, 0, 0, 32'h0), e_idle()});

    // All ports request continuously: rotation 0,1,2,0,1,2 with an IDLE bubble each.
    for (int t = 0; t < 6; t++) begin
      vecs.push_back({mk_in(3'b111, 12'h000, 1, 1, (t == 4), 32'h1000 + t), e_idle()});
      e = e_cmd(t % 3, 1, 4'h0);
      e.acc = 3'b001 << (t % 3);
      e.ack = 3'b001 << (t % 3);
      e.err = (t == 4) ? (3'b001 << (t % 3)) : 3'b000;
      e.rdata = 32'h1000 + t;
      vecs.push_back({mk_in(3'b111, 12'h000, 1, 1, (t == 4), 32'h1000 + t), e});
    end
    vecs.push_back({mk_in(3'b000, 12'h000, 0, 0, 0, 32'h0), e_idle()});

    for (int n = 0; n < vecs.size(); n++)
      step(vecs[n].i, vecs[n].e, $sformatf("vec%0d", n));

    // Watchdog: port 0 is never accepted and is aborted on its fourth CMD cycle.
    step(mk_in(3'b011, 12'h000, 0, 0, 0, 32'h0), e_idle(), "tmo_idle");
    for (int k = 0; k < 3; k++)
      step(mk_in(3'b011, 12'h000, 0, 0, 0, 32'h0), e_cmd(0, 1, 4'h0), $sformatf("tmo_cmd%0d", k));
    e = e_cmd(0, 0, 4'h0); e.ack = 3'b001; e.err = 3'b001;
    step(mk_in(3'b011, 12'h000, 0, 0, 0, 32'h0), e, "tmo_abort");
    step(mk_in(3'b010, 12'h000, 0, 0, 0, 32'h0), e_idle(), "tmo_bubble");
    e = e_cmd(1, 1, 4'h0); e.acc = 3'b010;
    step(mk_in(3'b010, 12'h000, 1, 0, 0, 32'h0), e, "tmo_p1_acc");
    e = e_wait(1); e.ack = 3'b010; e.rdata = 32'hCAFE_0001;
    step(mk_in(3'b000, 12'h000, 0, 1, 0, 32'hCAFE_0001), e, "tmo_p1_ack");
    step(mk_in(3'b000, 12'h000, 0, 0, 0, 32'h0), e_idle(), "tmo_done");

    // Withdrawal: port 1 drops its request in CMD, pending port 2 follows.
    step(mk_in(3'b010, 12'h000, 0, 0, 0, 32'h0), e_idle(), "wd_idle");
    step(mk_in(3'b110, 12'h000, 0, 0, 0, 32'h0), e_cmd(1, 1, 4'h0), "wd_cmd");
    step(mk_in(3'b100, 12'h000, 0, 0, 0, 32'h0), e_cmd(1, 0, 4'h0), "wd_drop");
    step(mk_in(3'b100, 12'h000, 0, 0, 0, 32'h0), e_idle(), "wd_bubble");
    e = e_cmd(2, 1, 4'h0); e.acc = 3'b100; e.ack = 3'b100; e.rdata = 32'h0BAD_0002;
    step(mk_in(3'b100, 12'h000, 1, 1, 0, 32'h0BAD_0002), e, "wd_p2");
    step(mk_in(3'b000, 12'h000, 0, 0, 0, 32'h0), e_idle(), "wd_done");

    // Reset while port 0 waits for its ack: silent abort and pointer restart.
    step(mk_in(3'b001, 12'h000, 0, 0, 0, 32'h0), e_idle(), "rst_idle");
    e = e_cmd(0, 1, 4'h0); e.acc = 3'b001;
    step(mk_in(3'b001, 12'h000, 1, 0, 0, 32'h0), e, "rst_acc");
    step(mk_in(3'b000, 12'h000, 0, 0, 0, 32'h0), e_wait(0), "rst_wait");
    rst = 1'b1;
    #1;
    check_output(e_idle(), "rst_async");
    @(negedge clk);
    rst = 1'b0;
    step(mk_in(3'b000, 12'h000, 0, 1, 0, 32'h5555_AAAA), e_idle(), "rst_late_ack");
    step(mk_in(3'b011, 12'h000, 0, 0, 0, 32'h0), e_idle(), "rst_req");
    e = e_cmd(0, 1, 4'h0); e.acc = 3'b001; e.ack = 3'b001; e.rdata = 32'h0000_0077;
    step(mk_in(3'b011, 12'h000, 1, 1, 0, 32'h0000_0077), e, "rst_p0");
    step(mk_in(3'b000, 12'h000, 0, 0, 0, 32'h0), e_idle(), "rst_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
